// File: rtl/ttc_chanb_frame_decoder.sv
// ============================================================================
// Module   : ttc_chanb_frame_decoder
// Function : TTC Channel B deserialiser; decodes short broadcast frames with
//            Hamming/framing checks, skips long frames, keeps error counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ttc_chanb_frame_decoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 chan_b_bit,
    input  logic                 chan_b_bit_valid,
    output logic [7:0]           brcst,
    output logic [5:0]           chan_b_info,
    output logic                 chan_b_valid,
    output logic                 evt_count_reset,
    output logic                 bcnt_reset,
    output logic [CNT_WIDTH-1:0] hamming_err_count,
    output logic [CNT_WIDTH-1:0] frame_err_count,
    output logic [CNT_WIDTH-1:0] long_frame_count
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fmt   = 3'd1;
    localparam logic [2:0] c_st_short = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_long  = 3'd4;

    localparam logic [5:0] c_short_last = 6'd12;  // 8 data + 5 Hamming bits
    localparam logic [5:0] c_long_last  = 6'd39;  // 40 bits after the format bit

    logic [2:0]           state_q,    state_d;
    logic [5:0]           bit_cnt_q,  bit_cnt_d;
    logic [12:0]          shift_q,    shift_d;
    logic [7:0]           brcst_q,    brcst_d;
    logic                 valid_q,    valid_d;
    logic                 evt_q,      evt_d;
    logic                 bcnt_q,     bcnt_d;
    logic [CNT_WIDTH-1:0] ham_cnt_q,  ham_cnt_d;
    logic [CNT_WIDTH-1:0] frm_cnt_q,  frm_cnt_d;
    logic [CNT_WIDTH-1:0] long_cnt_q, long_cnt_d;

    logic [7:0] w_data;
    logic [4:0] w_ham_rx;
    logic [4:0] w_ham_exp;

    // d7 is shifted in first, so it ends up at the top of the register
    assign w_data   = shift_q[12:5];
    assign w_ham_rx = shift_q[4:0];

    always_comb begin
        w_ham_exp[0] = w_data[0] ^ w_data[1] ^ w_data[2] ^ w_data[3];
        w_ham_exp[1] = w_data[0] ^ w_data[4] ^ w_data[5] ^ w_data[6];
        w_ham_exp[2] = w_data[1] ^ w_data[2] ^ w_data[4] ^ w_data[5] ^ w_data[7];
        w_ham_exp[3] = w_data[1] ^ w_data[3] ^ w_data[4] ^ w_data[6] ^ w_data[7];
        w_ham_exp[4] = (^w_data) ^ (^w_ham_exp[3:0]);
    end

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        brcst_d    = brcst_q;
        valid_d    = 1'b0;
        evt_d      = 1'b0;
        bcnt_d     = 1'b0;
        ham_cnt_d  = ham_cnt_q;
        frm_cnt_d  = frm_cnt_q;
        long_cnt_d = long_cnt_q;

        if (chan_b_bit_valid) begin
            case (state_q)
                c_st_idle: begin
                    if (!chan_b_bit) state_d = c_st_fmt;
                end
                c_st_fmt: begin
                    bit_cnt_d = 6'd0;
                    state_d   = chan_b_bit ? c_st_long : c_st_short;
                end
                c_st_short: begin
                    shift_d = {shift_q[11:0], chan_b_bit};
                    if (bit_cnt_q == c_short_last) state_d = c_st_stop;
                    else                           bit_cnt_d = bit_cnt_q + 6'd1;
                end
                c_st_stop: begin
                    // a bad stop bit takes precedence over a Hamming mismatch
                    state_d = c_st_idle;
                    if (!chan_b_bit) begin
                        frm_cnt_d = sat_inc(frm_cnt_q);
                    end else if (w_ham_rx != w_ham_exp) begin
                        ham_cnt_d = sat_inc(ham_cnt_q);
                    end else begin
                        brcst_d = w_data;
                        valid_d = 1'b1;
                        evt_d   = w_data[1];
                        bcnt_d  = w_data[0];
                    end
                end
                c_st_long: begin
                    if (bit_cnt_q == c_long_last) begin
                        state_d    = c_st_idle;
                        long_cnt_d = sat_inc(long_cnt_q);
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end
                end
                default: state_d = c_st_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= c_st_idle;
            bit_cnt_q  <= 6'd0;
            shift_q    <= 13'd0;
            brcst_q    <= 8'd0;
            valid_q    <= 1'b0;
            evt_q      <= 1'b0;
            bcnt_q     <= 1'b0;
            ham_cnt_q  <= '0;
            frm_cnt_q  <= '0;
            long_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            brcst_q    <= brcst_d;
            valid_q    <= valid_d;
            evt_q      <= evt_d;
            bcnt_q     <= bcnt_d;
            ham_cnt_q  <= ham_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
            long_cnt_q <= long_cnt_d;
        end
    end

    assign brcst             = brcst_q;
    assign chan_b_info       = brcst_q[7:2];
    assign chan_b_valid      = valid_q;
    assign evt_count_reset   = evt_q;
    assign bcnt_reset        = bcnt_q;
    assign hamming_err_count = ham_cnt_q;
    assign frame_err_count   = frm_cnt_q;
    assign long_frame_count  = long_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ttc_chanb_frame_decoder.sv
// ============================================================================
// Module   : tb_ttc_chanb_frame_decoder
// Function : Directed self-checking bench for ttc_chanb_frame_decoder.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ttc_chanb_frame_decoder;

    localparam int CNT_WIDTH = 4;  // narrow counters keep the saturation run short

    logic                 clk;
    logic                 reset_n;
    logic                 chan_b_bit;
    logic                 chan_b_bit_valid;
    logic [7:0]           brcst;
    logic [5:0]           chan_b_info;
    logic                 chan_b_valid;
    logic                 evt_count_reset;
    logic                 bcnt_reset;
    logic [CNT_WIDTH-1:0] hamming_err_count;
    logic [CNT_WIDTH-1:0] frame_err_count;
    logic [CNT_WIDTH-1:0] long_frame_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    logic [5:0] last_info;
    logic       last_evt;
    logic       last_bcnt;

    ttc_chanb_frame_decoder #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .chan_b_bit        (chan_b_bit),
        .chan_b_bit_valid  (chan_b_bit_valid),
        .brcst             (brcst),
        .chan_b_info       (chan_b_info),
        .chan_b_valid      (chan_b_valid),
        .evt_count_reset   (evt_count_reset),
        .bcnt_reset        (bcnt_reset),
        .hamming_err_count (hamming_err_count),
        .frame_err_count   (frame_err_count),
        .long_frame_count  (long_frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chan_b_valid) begin
            n_strobe  = n_strobe + 1;
            last_info = chan_b_info;
            last_evt  = evt_count_reset;
            last_bcnt = bcnt_reset;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] short_frame(input logic [7:0] d);
        logic h0, h1, h2, h3, h4;
        h0 = d[0] ^ d[1] ^ d[2] ^ d[3];
        h1 = d[0] ^ d[4] ^ d[5] ^ d[6];
        h2 = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7];
        h3 = d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[7];
        h4 = d[0] ^ d[1] ^ d[2] ^ d[3] ^ d[4] ^ d[5] ^ d[6] ^ d[7] ^ h0 ^ h1 ^ h2 ^ h3;
        return {1'b0, 1'b0, d, h4, h3, h2, h1, h0, 1'b1};
    endfunction

    // Drive one valid bit; returns on the falling edge after it was sampled.
    task automatic send_bit(input logic b);
        @(negedge clk);
        chan_b_bit       = b;
        chan_b_bit_valid = 1'b1;
        @(negedge clk);
        chan_b_bit_valid = 1'b0;
        chan_b_bit       = 1'b1;
    endtask

    task automatic send_short(input logic [15:0] f, input int max_gap);
        for (int i = 15; i >= 0; i--) begin
            send_bit(f[i]);
            if (i != 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    task automatic send_long(input logic [39:0] tail);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int i = 39; i >= 0; i--) send_bit(tail[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int s0;
        logic [15:0] f;
        reset_n          = 1'b0;
        chan_b_bit       = 1'b1;
        chan_b_bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("reset_brcst", brcst, 8'h00);
        chk("reset_info", chan_b_info, 6'h00);
        chk("reset_valid", chan_b_valid, 1'b0);
        chk("reset_evt", evt_count_reset, 1'b0);
        chk("reset_bcnt", bcnt_reset, 1'b0);
        chk("reset_ham_cnt", hamming_err_count, 0);
        chk("reset_frm_cnt", frame_err_count, 0);
        chk("reset_long_cnt", long_frame_count, 0);

        // Reset mid-frame, then a clean 0x3A
        f = short_frame(8'hC5);
        for (int i = 15; i >= 10; i--) send_bit(f[i]);
        do_reset();
        chk("midrst_no_strobe", n_strobe, 0);
        send_short(short_frame(8'h3A), 0);
        repeat (2) @(negedge clk);
        chk("midrst_strobes", n_strobe, 1);
        chk("midrst_brcst", brcst, 8'h3A);
        chk("midrst_ham_cnt", hamming_err_count, 0);
        chk("midrst_frm_cnt", frame_err_count, 0);
        chk("midrst_long_cnt", long_frame_count, 0);

        // Clean 0x0E with random gaps; exact one-cycle strobe after stop bit
        s0 = n_strobe;
        send_short(short_frame(8'h0E), 3);
        chk("0e_valid", chan_b_valid, 1'b1);
        chk("0e_info", chan_b_info, 6'b000011);
        chk("0e_evt", evt_count_reset, 1'b1);
        chk("0e_bcnt", bcnt_reset, 1'b0);
        @(negedge clk);
        chk("0e_valid_drop", chan_b_valid, 1'b0);
        chk("0e_evt_drop", evt_count_reset, 1'b0);
        repeat (10) @(negedge clk);
        chk("0e_brcst_hold", brcst, 8'h0E);
        chk("0e_strobes", n_strobe - s0, 1);

        // Every single payload bit flipped in turn
        s0 = n_strobe;
        for (int i = 0; i < 13; i++) begin
            f = short_frame(8'h5C);
            f[1 + i] = ~f[1 + i];
            send_short(f, 1);
        end
        repeat (2) @(negedge clk);
        chk("ham_strobes", n_strobe - s0, 0);
        chk("ham_cnt", hamming_err_count, 13);
        chk("ham_brcst", brcst, 8'h0E);
        chk("ham_frm_cnt", frame_err_count, 0);

        // Stop bit 0, then next frame immediately
        s0 = n_strobe;
        f = short_frame(8'h81);
        f[0] = 1'b0;
        send_short(f, 0);
        send_short(short_frame(8'h42), 0);
        repeat (2) @(negedge clk);
        chk("stop0_frm_cnt", frame_err_count, 1);
        chk("stop0_ham_cnt", hamming_err_count, 13);
        chk("stop0_strobes", n_strobe - s0, 1);
        chk("stop0_brcst", brcst, 8'h42);
        chk("stop0_info", last_info, 6'h10);

        // Long frame then short 0x01 back-to-back
        s0 = n_strobe;
        send_long(40'hA50F3C967F);
        send_short(short_frame(8'h01), 0);
        repeat (2) @(negedge clk);
        chk("long_cnt", long_frame_count, 1);
        chk("long_strobes", n_strobe - s0, 1);
        chk("long_bcnt", last_bcnt, 1'b1);
        chk("long_evt", last_evt, 1'b0);
        chk("long_brcst", brcst, 8'h01);

        // Saturation: 2^CNT_WIDTH+3 Hamming errors
        do_reset();
        for (int i = 0; i < (1 << CNT_WIDTH) + 3; i++) begin
            f = short_frame(i[7:0]);
            f[3] = ~f[3];
            send_short(f, 0);
        end
        repeat (2) @(negedge clk);
        chk("sat_ham_cnt", hamming_err_count, {CNT_WIDTH{1'b1}});
        chk("sat_frm_cnt", frame_err_count, 0);
        chk("sat_long_cnt", long_frame_count, 0);
        chk("sat_brcst", brcst, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
